// File: rtl/gpio_wiggle_gen.sv
// GPIO pattern generator: TOGGLE/WALK/COUNT/GRAY at a prescaled step rate, bounded or free-running.
// Optional loopback checking when GPIO_WIGGLE_LOOPBACK_EN is defined.
module gpio_wiggle_gen #(
    parameter int WIDTH = 32,
    parameter int DIV_W = 24,
    parameter int CNT_W = 16
) (
    input  logic             osc,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] div,
    input  logic [CNT_W-1:0] steps,
    input  logic             start,
    input  logic             stop,
`ifdef GPIO_WIGGLE_LOOPBACK_EN
    input  logic [WIDTH-1:0] gpio_in,
    output logic             mismatch,
    output logic [15:0]      err_cnt,
`endif
    output logic [WIDTH-1:0] gpio_out,
    output logic             busy,
    output logic             done,
    output logic             step_strobe
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [1:0] M_TOGGLE = 2'd0;
    localparam logic [1:0] M_WALK   = 2'd1;
    localparam logic [1:0] M_COUNT  = 2'd2;

    state_t           state_q;
    logic [1:0]       mode_q;
    logic [DIV_W-1:0] div_q;
    logic [CNT_W-1:0] steps_q;
    logic [DIV_W-1:0] pcnt_q;
    logic [CNT_W-1:0] scnt_q;
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] gpio_q;
    logic             busy_q;
    logic             done_q;
    logic             strobe_q;

    logic [WIDTH-1:0] pat_d;
    logic [WIDTH-1:0] gray_d;
    logic [CNT_W-1:0] scnt_d;
    logic             step;
    logic             go;

    assign step   = (state_q == S_RUN) && (pcnt_q == div_q);
    assign go     = (state_q == S_IDLE) && start && !stop;
    assign scnt_d = scnt_q + 1'b1;

    always_comb begin
        gray_d = gray_q + 1'b1;
        case (mode_q)
            M_TOGGLE: pat_d = ~gpio_q;
            M_WALK:   pat_d = {gpio_q[WIDTH-2:0], gpio_q[WIDTH-1]};
            M_COUNT:  pat_d = gpio_q + 1'b1;
            default:  pat_d = gray_d ^ (gray_d >> 1);
        endcase
    end

    always_ff @(posedge osc) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mode_q   <= '0;
            div_q    <= '0;
            steps_q  <= '0;
            pcnt_q   <= '0;
            scnt_q   <= '0;
            gray_q   <= '0;
            gpio_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            strobe_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (go) begin
                        state_q <= S_RUN;
                        mode_q  <= mode;
                        div_q   <= div;
                        steps_q <= steps;
                        pcnt_q  <= '0;
                        scnt_q  <= '0;
                        gray_q  <= '0;
                        gpio_q  <= (mode == M_WALK) ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (step) begin
                        pcnt_q   <= '0;
                        gpio_q   <= pat_d;
                        gray_q   <= gray_d;
                        strobe_q <= 1'b1;
                        // Saturate so free-run never wraps the count.
                        if (scnt_q != '1) scnt_q <= scnt_d;
                    end else begin
                        pcnt_q <= pcnt_q + 1'b1;
                    end
                    if (stop) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (step && (steps_q != '0) && (scnt_d == steps_q)) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign gpio_out    = gpio_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign step_strobe = strobe_q;

`ifdef GPIO_WIGGLE_LOOPBACK_EN
    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic             mism_q;
    logic [15:0]      err_q;
    logic             cmp_en;

    // Need two stable cycles since the last step before the synchroniser output is valid.
    assign cmp_en = step && (div_q[DIV_W-1:1] != '0);

    always_ff @(posedge osc) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            mism_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            sync1_q <= gpio_in;
            sync2_q <= sync1_q;
            if (go) begin
                mism_q <= 1'b0;
                err_q  <= '0;
            end else if (cmp_en && (sync2_q != gpio_q)) begin
                mism_q <= 1'b1;
                if (err_q != 16'hFFFF) err_q <= err_q + 16'd1;
            end
        end
    end

    assign mismatch = mism_q;
    assign err_cnt  = err_q;
`endif

endmodule
